// File: rtl/axi_wr_slave_mem.sv
// AXI4 write-channel slave backed by a word-addressed memory.
// One outstanding burst, byte strobes, FIXED/INCR, registered debug read port.
module axi_wr_slave_mem #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int MEM_DEPTH      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic [1:0]                    s_axi_awburst,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [$clog2(MEM_DEPTH)-1:0]  dbg_addr,
    output logic [AXI_DATA_WIDTH-1:0]     dbg_rdata
);

    localparam int STRB_BYTES = AXI_DATA_WIDTH / 8;
    localparam int SIZE_LOG   = $clog2(STRB_BYTES);
    localparam int IDX_W      = AXI_ADDR_WIDTH + 1;
    localparam int DBG_W      = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                  state_q, state_d;
    logic [AXI_ID_WIDTH-1:0] id_q, id_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    fixed_q, fixed_d;
    logic                    aw_err_q, aw_err_d;
    logic                    err_q, err_d;
    logic                    mem_we;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Signed offset keeps an address below BASE_ADDR negative, hence out of range
    logic signed [IDX_W-1:0] aw_off;
    logic [IDX_W-1:0]        aw_idx;
    logic                    aw_bad;
    logic                    in_range;
    logic                    last;

    assign aw_off   = $signed({1'b0, s_axi_awaddr} - {1'b0, BASE_ADDR});
    assign aw_idx   = aw_off >>> SIZE_LOG;
    assign aw_bad   = (s_axi_awsize != 3'(SIZE_LOG)) || s_axi_awburst[1];
    assign in_range = !idx_q[IDX_W-1] && (idx_q < IDX_W'(MEM_DEPTH));
    assign last     = (cnt_q == 8'd0);

    assign s_axi_awready = (state_q == IDLE);
    assign s_axi_wready  = (state_q == DATA);
    assign s_axi_bvalid  = (state_q == RESP);
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = err_q ? 2'b10 : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            id_q     <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            fixed_q  <= 1'b0;
            aw_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            fixed_q  <= fixed_d;
            aw_err_q <= aw_err_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        fixed_d  = fixed_q;
        aw_err_d = aw_err_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_axi_awvalid) begin
                    id_d     = s_axi_awid;
                    idx_d    = aw_idx;
                    cnt_d    = s_axi_awlen;
                    fixed_d  = (s_axi_awburst == 2'b00);
                    aw_err_d = aw_bad;
                    err_d    = aw_bad;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (s_axi_wvalid) begin
                    mem_we = !aw_err_q && in_range;
                    if (!in_range || (s_axi_wlast != last))
                        err_d = 1'b1;
                    if (!fixed_q)
                        idx_d = idx_q + IDX_W'(1);
                    cnt_d = cnt_q - 8'd1;
                    if (last)
                        state_d = RESP;
                end
            end
            RESP: begin
                if (s_axi_bready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory is deliberately not reset; debug read sees pre-write data
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_BYTES; b++) begin
                if (s_axi_wstrb[b])
                    mem[idx_q[DBG_W-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
        dbg_rdata <= mem[dbg_addr];
    end

endmodule
